// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA controller: state encoding, word width and burst
// length (BURST_LEN is also the cache line size, so the cache imports it from here).
package dma_controller_pkg;

   localparam int WORD_SIZE = 16;
   localparam int BURST_LEN = 4;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      XFER,
      REL,
      DONE
   } dma_state_e;

endpackage

// File: rtl/dma_addr_gen.sv
// Address generator: base + index with natural modulo-2^WORD_SIZE wrap, and a flag
// marking the index that finishes a burst. BURST_LEN is expected to be a power of two.
module dma_addr_gen #(
   parameter int WORD_SIZE = dma_controller_pkg::WORD_SIZE,
   parameter int BURST_LEN = dma_controller_pkg::BURST_LEN
) (
   input  logic [WORD_SIZE-1:0] base,
   input  logic [WORD_SIZE-1:0] index,
   output logic [WORD_SIZE-1:0] address,
   output logic                 burst_end
);
   import dma_controller_pkg::*;

   logic [31:0] next_count;

   // burst_end is true when accepting the word at this index completes a burst
   always_comb begin
      address    = base + index;
      next_count = 32'(index) + 32'd1;
      burst_end  = (next_count % 32'(BURST_LEN)) == 32'd0;
   end

endmodule

// File: rtl/dma_controller.sv
// Device-to-memory DMA controller with BR/BG bus arbitration.
// Optional feature: define DMA_CYCLE_STEAL_EN to release the bus for one cycle between bursts.
module dma_controller #(
   parameter int WORD_SIZE = dma_controller_pkg::WORD_SIZE,
   parameter int BURST_LEN = dma_controller_pkg::BURST_LEN
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   input  logic [WORD_SIZE-1:0] cmd_addr,
   input  logic [WORD_SIZE-1:0] cmd_len,
   output logic                 cmd_ready,
   output logic                 BR,
   input  logic                 BG,
   input  logic [WORD_SIZE-1:0] dev_data,
   input  logic                 dev_valid,
   output logic                 dev_ready,
   output logic [WORD_SIZE-1:0] dma_address,
   output logic [WORD_SIZE-1:0] dma_data,
   output logic                 dma_write,
   input  logic                 mem_ready,
   output logic                 dma_done,
   output logic                 busy
);
   import dma_controller_pkg::*;

   dma_state_e           state_q, state_d;
   logic [WORD_SIZE-1:0] base_q, base_d;
   logic [WORD_SIZE-1:0] len_q, len_d;
   logic [WORD_SIZE-1:0] index_q, index_d;
   logic [WORD_SIZE-1:0] cur_address;
   logic                 burst_end;
   logic                 last_word;

   dma_addr_gen #(
      .WORD_SIZE (WORD_SIZE),
      .BURST_LEN (BURST_LEN)
   ) u_addr_gen (
      .base      (base_q),
      .index     (index_q),
      .address   (cur_address),
      .burst_end (burst_end)
   );

   assign last_word = (index_q + WORD_SIZE'(1)) == len_q;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      index_d     = index_q;
      cmd_ready   = 1'b0;
      BR          = 1'b0;
      dev_ready   = 1'b0;
      dma_write   = 1'b0;
      dma_address = '0;
      dma_data    = '0;
      dma_done    = 1'b0;
      busy        = 1'b1;

      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               base_d  = cmd_addr;
               len_d   = cmd_len;
               index_d = '0;
               state_d = (cmd_len == '0) ? DONE : REQ;
            end
         end
         REQ: begin
            BR = 1'b1;
            if (BG) state_d = XFER;
         end
         XFER: begin
            BR = 1'b1;
            // An issued write always runs to completion, even if the grant is lost meanwhile
            if (dev_valid) begin
               dma_write   = 1'b1;
               dma_address = cur_address;
               dma_data    = dev_data;
               if (mem_ready) begin
                  dev_ready = 1'b1;
                  index_d   = index_q + WORD_SIZE'(1);
                  if (last_word) state_d = DONE;
                  else if (!BG)  state_d = REQ;
`ifdef DMA_CYCLE_STEAL_EN
                  else if (burst_end) state_d = REL;
`endif
               end
            end else if (!BG) begin
               state_d = REQ;
            end
         end
         REL: begin
            state_d = REQ;
         end
         DONE: begin
            dma_done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         len_q   <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         index_q <= index_d;
      end
   end

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: directed vector table, hand sequences for
// multi-cycle corners, and randomized transfers checked against a transaction model.
module tb_dma_controller;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic [15:0] cmd_addr;
   logic [15:0] cmd_len;
   logic        cmd_ready;
   logic        BR;
   logic        BG;
   logic [15:0] dev_data;
   logic        dev_valid;
   logic        dev_ready;
   logic [15:0] dma_address;
   logic [15:0] dma_data;
   logic        dma_write;
   logic        mem_ready;
   logic        dma_done;
   logic        busy;
   logic        cache_write_m2;

   int checks = 0;
   int errors = 0;

   dma_controller dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .cmd_ready   (cmd_ready),
      .BR          (BR),
      .BG          (BG),
      .dev_data    (dev_data),
      .dev_valid   (dev_valid),
      .dev_ready   (dev_ready),
      .dma_address (dma_address),
      .dma_data    (dma_data),
      .dma_write   (dma_write),
      .mem_ready   (mem_ready),
      .dma_done    (dma_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rn, cv;
      logic [15:0] ca, cl;
      logic        bg, dv;
      logic [15:0] dd;
      logic        mr;
      logic        e_br, e_wr;
      logic [15:0] e_addr, e_data;
      logic        e_dr, e_done, e_busy, e_cr;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic toDrive();
      @(posedge clk);
      #1;
   endtask

   task automatic toSample();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input vec_t t);
      toDrive();
      reset_n   = t.rn;
      cmd_valid = t.cv;
      cmd_addr  = t.ca;
      cmd_len   = t.cl;
      BG        = t.bg;
      dev_valid = t.dv;
      dev_data  = t.dd;
      mem_ready = t.mr;
      toSample();
   endtask

   function automatic vec_t mk(input logic rn, input logic cv, input logic [15:0] ca,
                               input logic [15:0] cl, input logic bg, input logic dv,
                               input logic [15:0] dd, input logic mr, input logic ebr,
                               input logic ew, input logic [15:0] ea, input logic [15:0] ed,
                               input logic edr, input logic edn, input logic eb, input logic ecr);
      vec_t t;
      t.rn = rn; t.cv = cv; t.ca = ca; t.cl = cl; t.bg = bg; t.dv = dv; t.dd = dd; t.mr = mr;
      t.e_br = ebr; t.e_wr = ew; t.e_addr = ea; t.e_data = ed;
      t.e_dr = edr; t.e_done = edn; t.e_busy = eb; t.e_cr = ecr;
      return t;
   endfunction

   task automatic add_reset();
      vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 1));
   endtask
   task automatic add_cmd(input logic [15:0] ca, input logic [15:0] cl);
      vecs.push_back(mk(1, 1, ca, cl, 0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 1));
   endtask
   task automatic add_req(input logic bg);
      vecs.push_back(mk(1, 0, 16'h0, 16'h0, bg, 1, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 0, 1, 0));
   endtask
   task automatic add_wr(input logic [15:0] ea, input logic [15:0] ed, input logic mr);
      vecs.push_back(mk(1, 0, 16'h0, 16'h0, 1, 1, ed, mr, 1, 1, ea, ed, mr, 0, 1, 0));
   endtask
   task automatic add_done();
      vecs.push_back(mk(1, 0, 16'h0, 16'h0, 0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0, 0, 1, 1, 0));
   endtask
   task automatic add_idle();
      vecs.push_back(mk(1, 0, 16'h0, 16'h0, 0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 1));
   endtask

   task automatic run_table();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("row%0d_BR", i),          BR,          vecs[i].e_br);
         checkOutput($sformatf("row%0d_dma_write", i),   dma_write,   vecs[i].e_wr);
         checkOutput($sformatf("row%0d_dma_address", i), dma_address, vecs[i].e_addr);
         checkOutput($sformatf("row%0d_dma_data", i),    dma_data,    vecs[i].e_data);
         checkOutput($sformatf("row%0d_dev_ready", i),   dev_ready,   vecs[i].e_dr);
         checkOutput($sformatf("row%0d_dma_done", i),    dma_done,    vecs[i].e_done);
         checkOutput($sformatf("row%0d_busy", i),        busy,        vecs[i].e_busy);
         checkOutput($sformatf("row%0d_cmd_ready", i),   cmd_ready,   vecs[i].e_cr);
      end
   endtask

   task automatic idle_inputs();
      cmd_valid = 0; cmd_addr = 0; cmd_len = 0; BG = 0; dev_valid = 0; dev_data = 0; mem_ready = 1;
   endtask

   // Burst of len words with BG/dev_valid/mem_ready held high; optionally spam ignored commands
   task automatic run_steady(input string tag, input logic [15:0] base, input logic [15:0] len,
                             input logic spam, output int nwr, output int gaps, output int gap_at);
      logic seen_br = 0;
      logic done = 0;
      nwr = 0; gaps = 0; gap_at = -1;
      toDrive();
      reset_n = 1; cmd_valid = 1; cmd_addr = base; cmd_len = len;
      BG = 1; dev_valid = 1; dev_data = 16'hD000; mem_ready = 1;
      toSample();
      checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
      for (int k = 0; k < 60 && !done; k++) begin
         toDrive();
         cmd_valid = spam; cmd_addr = 16'h0700; cmd_len = 16'd8;
         dev_data  = 16'hD000 + 16'(nwr);
         toSample();
         if (dma_write) begin
            checkOutput({tag, "_addr"}, dma_address, base + 16'(nwr));
            nwr++;
         end
         if (BR) seen_br = 1;
         else if (seen_br && !dma_done) begin
            if (gaps == 0) gap_at = nwr;
            gaps++;
         end
         if (dma_done) done = 1;
      end
      checkOutput({tag, "_done_seen"}, done, 1);
      toDrive();
      idle_inputs();
      toSample();
   endtask

   // Randomized transfers; the model is a queue of expected (address) writes per command
   task automatic randomTest(input int ntx);
      logic [15:0] exp_q[$];
      logic [15:0] base, len, dd;
      logic        dv = 0;
      logic        consumed = 0;
      logic        done;
      for (int t = 0; t < ntx; t++) begin
         base = 16'($urandom());
         if (t == 0) base = 16'hFFF9;
         len  = 16'(4 * $urandom_range(0, 4));
         exp_q.delete();
         for (int i = 0; i < int'(len); i++) exp_q.push_back(base + 16'(i));
         toDrive();
         cmd_valid = 1; cmd_addr = base; cmd_len = len; BG = 0;
         mem_ready = 1'($urandom_range(0, 1)); cache_write_m2 = 1'($urandom_range(0, 1));
         toSample();
         checkOutput("rnd_cmd_ready", cmd_ready, 1);
         consumed = 0;
         done = 0;
         for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            toDrive();
            if (consumed || !dv) begin
               dv = 1'($urandom_range(0, 1));
               dd = 16'($urandom());
            end
            dev_valid = dv; dev_data = dd;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_addr  = 16'($urandom());
            cmd_len   = 16'(4 * $urandom_range(1, 3));
            mem_ready = ($urandom_range(0, 3) != 0);
            BG = BR && (dv || ($urandom_range(0, 3) != 0));
            cache_write_m2 = !BG && 1'($urandom_range(0, 1));
            toSample();
            checkOutput("rnd_busy", busy, 1);
            checkOutput("rnd_cmd_ready_busy", cmd_ready, 0);
            checkOutput("rnd_m2_overlap", dma_write && cache_write_m2, 0);
            checkOutput("rnd_dev_ready", dev_ready, dma_write && mem_ready);
            if (dma_write) begin
               if (exp_q.size() == 0) checkOutput("rnd_extra_write", dma_write, 0);
               else begin
                  checkOutput("rnd_addr", dma_address, exp_q[0]);
                  checkOutput("rnd_data", dma_data, dd);
                  if (dev_ready) void'(exp_q.pop_front());
               end
            end
            consumed = dev_ready && dev_valid;
            if (dma_done) begin
               checkOutput("rnd_done_remaining", exp_q.size(), 0);
               checkOutput("rnd_done_br", BR, 0);
               done = 1;
            end
         end
         if (!done) checkOutput("rnd_done_timeout", done, 1);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int nwr, gaps, gap_at;
      reset_n = 0;
      cache_write_m2 = 0;
      idle_inputs();
      repeat (2) @(posedge clk);

      // Basic transfer, memory stall, and address wrap
      add_reset();
      add_cmd(16'h0010, 16'd4);
      add_req(0); add_req(0); add_req(1);
      add_wr(16'h0010, 16'hA000, 1); add_wr(16'h0011, 16'hA001, 1);
      add_wr(16'h0012, 16'hA002, 1); add_wr(16'h0013, 16'hA003, 1);
      add_done(); add_idle();
      add_cmd(16'h0010, 16'd4);
      add_req(1);
      add_wr(16'h0010, 16'hB000, 1); add_wr(16'h0011, 16'hB001, 1);
      add_wr(16'h0012, 16'hB002, 0); add_wr(16'h0012, 16'hB002, 0);
      add_wr(16'h0012, 16'hB002, 1); add_wr(16'h0013, 16'hB003, 1);
      add_done(); add_idle();
      add_cmd(16'hFFFE, 16'd4);
      add_req(1);
      add_wr(16'hFFFE, 16'hC000, 1); add_wr(16'hFFFF, 16'hC001, 1);
      add_wr(16'h0000, 16'hC002, 1); add_wr(16'h0001, 16'hC003, 1);
      add_done(); add_idle();
      run_table();

      // Two bursts: bus released exactly once between them only with cycle stealing
      run_steady("steal", 16'h0100, 16'd8, 0, nwr, gaps, gap_at);
      checkOutput("steal_writes", nwr, 8);
`ifdef DMA_CYCLE_STEAL_EN
      checkOutput("steal_br_gaps", gaps, 1);
      checkOutput("steal_gap_after", gap_at, 4);
`else
      checkOutput("steal_br_gaps", gaps, 0);
`endif

      // Commands while busy are ignored
      run_steady("ignore", 16'h0200, 16'd4, 1, nwr, gaps, gap_at);
      checkOutput("ignore_writes", nwr, 4);

      // Zero-length command completes without requesting the bus
      toDrive(); idle_inputs(); cmd_valid = 1; cmd_addr = 16'h0055; cmd_len = 0; toSample();
      checkOutput("len0_cmd_ready", cmd_ready, 1);
      toDrive(); cmd_valid = 0; toSample();
      checkOutput("len0_done", dma_done, 1);
      checkOutput("len0_br", BR, 0);
      toDrive(); toSample();
      checkOutput("len0_done_once", dma_done, 0);
      checkOutput("len0_br_after", BR, 0);
      checkOutput("len0_busy_after", busy, 0);

      // Grant lost with a write in flight: write completes, then bus is re-requested
      toDrive(); idle_inputs(); cmd_valid = 1; cmd_addr = 16'h0040; cmd_len = 4; toSample();
      toDrive(); cmd_valid = 0; BG = 1; toSample();
      toDrive(); BG = 0; dev_valid = 1; dev_data = 16'hE000; mem_ready = 0; toSample();
      checkOutput("perr_stall_write", dma_write, 1);
      checkOutput("perr_stall_addr", dma_address, 16'h0040);
      checkOutput("perr_stall_dev_ready", dev_ready, 0);
      toDrive(); mem_ready = 1; toSample();
      checkOutput("perr_accept_dev_ready", dev_ready, 1);
      toDrive(); dev_data = 16'hE001; toSample();
      checkOutput("perr_req_write", dma_write, 0);
      checkOutput("perr_req_br", BR, 1);
      toDrive(); BG = 1; toSample();
      checkOutput("perr_req2_write", dma_write, 0);
      for (int i = 1; i < 4; i++) begin
         toDrive(); dev_data = 16'hE000 + 16'(i); toSample();
         checkOutput("perr_resume_addr", dma_address, 16'h0040 + 16'(i));
         checkOutput("perr_resume_data", dma_data, 16'hE000 + 16'(i));
      end
      toDrive(); idle_inputs(); toSample();
      checkOutput("perr_done", dma_done, 1);

      // Reset after the first word: abort, outputs return to reset values, no done pulse
      toDrive(); idle_inputs(); cmd_valid = 1; cmd_addr = 16'h0300; cmd_len = 4; toSample();
      toDrive(); cmd_valid = 0; BG = 1; dev_valid = 1; dev_data = 16'hF000; toSample();
      toDrive(); toSample();
      checkOutput("rst_word1_write", dma_write, 1);
      toDrive(); reset_n = 0; toSample();
      toDrive(); reset_n = 1; toSample();
      checkOutput("rst_BR", BR, 0);
      checkOutput("rst_dma_write", dma_write, 0);
      checkOutput("rst_dev_ready", dev_ready, 0);
      checkOutput("rst_dma_done", dma_done, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_cmd_ready", cmd_ready, 1);
      checkOutput("rst_dma_address", dma_address, 0);
      checkOutput("rst_dma_data", dma_data, 0);
      for (int i = 0; i < 6; i++) begin
         toDrive(); toSample();
         checkOutput("rst_no_done", dma_done, 0);
      end
      toDrive(); idle_inputs(); toSample();

      randomTest(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
